// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: data width, signed data type
// and the sign-bit ReLU clamp used by the standalone ReLU stage.
package conv_pkg;

  localparam int DATA_W = 48;

  typedef logic signed [DATA_W-1:0] data_t;

  function automatic data_t relu_fn(input data_t d);
    return d[DATA_W-1] ? '0 : d;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from the request vector and
// an internal priority pointer that moves past the winner after each grant.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N-1:0]     i_req,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_v
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cand;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_v   = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % N);
      if (!o_gnt_v && i_req[cand]) begin
        o_gnt_v     = 1'b1;
        o_gnt[cand] = 1'b1;
        o_gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr <= '0;
    end else if (o_gnt_v) begin
      rr_ptr <= (o_gnt_idx == LAST) ? '0 : o_gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/relu_scheduler.sv
// Shares one registered ReLU stage among N_CH accumulator lanes: one-deep
// per-lane holding buffers, round-robin selection, tagged single output stream.
module relu_scheduler #(
  parameter int N_CH   = 4,
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int CH_W   = $clog2(N_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_CH-1:0]          i_en,
  input  logic [N_CH*DATA_W-1:0]   i_data,
  input  logic                     i_bypass,
  output logic [N_CH-1:0]          o_full,
  output logic                     o_en,
  output logic [DATA_W-1:0]        o_data,
  output logic [CH_W-1:0]          o_ch,
  output logic [N_CH-1:0]          o_overflow,
  output logic                     o_idle
);

  function automatic logic signed [DATA_W-1:0] relu_clamp(input logic signed [DATA_W-1:0] d);
    return d[DATA_W-1] ? '0 : d;
  endfunction

  logic [N_CH-1:0]          buf_v_p0;
  logic signed [DATA_W-1:0] buf_d_p0 [N_CH];

  logic [N_CH-1:0]          gnt;
  logic [CH_W-1:0]          gnt_idx;
  logic                     gnt_v;
  logic [N_CH-1:0]          accept;
  logic [N_CH-1:0]          drop;
  logic [N_CH-1:0]          buf_v_nxt;
  logic signed [DATA_W-1:0] gnt_d;

  logic                     vld_p1;
  logic signed [DATA_W-1:0] data_p1;
  logic [CH_W-1:0]          ch_p1;
  logic [N_CH-1:0]          ovf;
  logic                     idle;

  rr_arbiter #(
    .N     (N_CH),
    .IDX_W (CH_W)
  ) u_arb (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (buf_v_p0),
    .o_gnt     (gnt),
    .o_gnt_idx (gnt_idx),
    .o_gnt_v   (gnt_v)
  );

  // A granted lane frees its slot this edge, so it may refill in the same cycle.
  always_comb begin
    accept    = i_en & (~buf_v_p0 | gnt);
    drop      = i_en & buf_v_p0 & ~gnt;
    buf_v_nxt = accept | (buf_v_p0 & ~gnt);
    gnt_d     = buf_d_p0[gnt_idx];
  end

  // Stage p0: per-lane holding buffers
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (accept[k]) begin
        buf_d_p0[k] <= i_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Stage p1: shared ReLU output register and status flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      buf_v_p0 <= '0;
      ovf      <= '0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      ch_p1    <= '0;
      idle     <= 1'b1;
    end else begin
      buf_v_p0 <= buf_v_nxt;
      ovf      <= ovf | drop;
      vld_p1   <= gnt_v;
      if (gnt_v) begin
        ch_p1   <= gnt_idx;
        data_p1 <= i_bypass ? gnt_d : relu_clamp(gnt_d);
      end else begin
        data_p1 <= '0;
      end
      idle <= !(|buf_v_nxt) && !gnt_v;
    end
  end

  assign o_full     = buf_v_p0;
  assign o_en       = vld_p1;
  assign o_data     = data_p1;
  assign o_ch       = ch_p1;
  assign o_overflow = ovf;
  assign o_idle     = idle;

endmodule

// File: doc/relu_scheduler.md
# relu_scheduler

Shares one registered ReLU stage among `N_CH` parallel convolution lanes. Each lane's 48-bit signed accumulator result is captured in a one-deep per-lane holding buffer. A round-robin arbiter then forwards one buffered result per cycle through ReLU to a single tagged output stream. It sits between the parallel MAC/accumulator lanes and the pooling/write-back stage.

## Interface
- `N_CH`, 4: number of lanes, ≥2.
- `DATA_W`, 48: accumulator/data width, signed.
- `CH_W`, `$clog2(N_CH)`: lane-index width.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_en`  in  `N_CH`  per-lane result strobe, one cycle per result.
- `i_data`  in  `N_CH*DATA_W`  per-lane signed result; lane k is `[k*DATA_W +: DATA_W]`.
- `i_bypass`  in  1  1 = pass data unchanged; 0 = apply ReLU. Sampled at grant.
- `o_full`  out  `N_CH`  registered; lane k holding buffer occupied.
- `o_en`  out  1  output valid, one cycle per result.
- `o_data`  out  `DATA_W`  signed result after ReLU/bypass.
- `o_ch`  out  `CH_W`  lane index of `o_data`.
- `o_overflow`  out  `N_CH`  sticky per lane; a strobe was dropped.
- `o_idle`  out  1  registered; no buffer occupied and no output pending.

## Operation
- Per-lane buffer: `buf_v[k]`, `buf_d[k]`.
- Accept rule: lane k accepts `i_en[k]` when `!buf_v[k]`, or when lane k is granted in the same cycle (simultaneous free and refill). On accept, `buf_v[k]` is set and `buf_d[k]` is updated.
- Drop rule: `i_en[k]` while `buf_v[k]` and not granted drops the data, leaves the buffer unchanged, and sets `o_overflow[k]`. Only `i_rst` clears `o_overflow`.
- Arbiter: requests are `buf_v`. The pointer `rr_ptr` names the highest-priority lane. The search runs `rr_ptr`, `rr_ptr+1`, … modulo `N_CH`, and the first set request wins. After a grant, `rr_ptr` = granted lane + 1, wrapping `N_CH-1` to 0. With no grant, `rr_ptr` holds.
- Grant clears `buf_v[g]` unless lane g refills in the same cycle.
- Output register, on a grant:
  - `o_en`=1 and `o_ch`=g.
  - `o_data` = `buf_d[g]` if `i_bypass`.
  - Otherwise `o_data` = 0 when `buf_d[g][DATA_W-1]`=1, else `buf_d[g]`.
- With no grant: `o_en`=0 and `o_data`=0. `o_ch` holds.
- Throughput: one result per cycle aggregate. Each lane is guaranteed a grant within `N_CH` cycles of its buffer filling.
- Arithmetic: no width change and no saturation. The most-negative value maps to 0 in ReLU mode.

## Timing
- Reset values: `o_en`=0, `o_data`=0, `o_ch`=0, `o_full`=0, `o_overflow`=0, `o_idle`=1; internally `rr_ptr`=0 and `buf_v`=0.
- Reset mid-operation: buffered data is discarded and no output follows. `i_en` in a cycle where `i_rst`=1 is ignored.
- Latency with an uncontended lane: `i_en` at edge t; buffer valid after t; granted at edge t+1; `o_en`/`o_data` valid after t+1. That is 2 edges from strobe to output.
- Contention: a lane waits at most `N_CH-1` extra cycles.
- `o_full` reflects the buffer state after the current edge. A producer may strobe every cycle only if its lane is granted every cycle, which means it must be the sole active lane.
- `o_idle` = `!(|buf_v)` and `!o_en`.

## Structure
- Shared package `conv_pkg`: `DATA_W`=48, a signed data typedef, the `relu_fn` function (sign-bit clamp) for reuse by the standalone ReLU stage.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs: `i_clk`, `i_rst`, `i_req[N]`.
  - Outputs: `o_gnt[N]` (one-hot, combinational from req and pointer), `o_gnt_idx`, `o_gnt_v`.
  - Pointer updates inside on `o_gnt_v`.
- The top holds the buffers, accept/drop logic, ReLU output register, and flags.

## Test plan
- Reset then single lane: `i_en[2]` with data −5, then data 7, two cycles apart. Expect `o_en`=1, `o_ch`=2, `o_data`=0, then `o_data`=7, each 2 edges after its strobe.
- All 4 lanes strobe in the same cycle with data 10, −1, 30, 40. Expect outputs on 4 consecutive cycles with `o_ch` = 0,1,2,3 and `o_data` = 10,0,30,40. `o_idle` returns to 1 afterwards.
- Round-robin fairness: lanes 0 and 3 strobe every time their buffer frees for 20 cycles. Expect `o_ch` to alternate 0,3,0,3…, no overflow, and aggregate one output per cycle.
- Overflow: lanes 0 and 1 strobe together, lane 1 wins no grant, and lane 1 strobes again the next cycle. Expect `o_overflow[1]`=1 (sticky), the first lane-1 value emitted, and the second value lost.
- Bypass and boundary: `i_bypass`=1 with data `48'h8000_0000_0000` outputs unchanged. The same input with `i_bypass`=0 outputs 0. Data `48'h7FFF_FFFF_FFFF` passes in both modes.
- Reset mid-operation: 3 lanes buffered, `i_rst` pulsed 1 cycle. Expect `o_en`=0 from the next edge, `o_full`=0, `o_overflow`=0, and the next grant order starting at lane 0.
